video_term_writer: RTL and testbench

- Character-stream front end that sits directly upstream of the character video memory.
- Accepts ASCII bytes over a valid/ready handshake and tracks a text cursor on the character grid.
- Interprets a small set of control codes, and emits single-cell write commands (address, character, enable) into the character memory write port.
- Performs power-up and form-feed screen clears; wraps from the bottom row to row 0, clearing the newly entered row.

---
 rtl/video_term_writer.sv | 161 ++++++++++++++++
 tb/tb_video_term_writer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_term_writer.sv
// rtl/video_term_writer.sv - character stream to character-memory write commands with cursor tracking
module video_term_writer #(
    parameter int         COLS   = 107,
    parameter int         ROWS   = 40,
    parameter int         ADDR_W = 13,
    parameter int         COL_W  = 7,
    parameter int         ROW_W  = 6,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic              write_clk,
    input  logic              rst_n,
    input  logic [7:0]        vm_ch_in,
    input  logic              vm_ch_valid,
    output logic              vm_ch_ready,
    output logic [ADDR_W-1:0] vm_wr_addr,
    output logic [7:0]        vm_wr_data,
    output logic              vm_wr_en,
    output logic [COL_W-1:0]  vm_cur_col,
    output logic [ROW_W-1:0]  vm_cur_row
);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CELLS_A  = ADDR_W'(COLS * ROWS);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_LINE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
    logic              line_skew, line_skew_nxt;
    logic [COL_W-1:0]  col, col_nxt;
    logic [ROW_W-1:0]  row, row_nxt;
    logic [ADDR_W-1:0] row_base, row_base_nxt;
    logic              wr_en_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [7:0]        wr_data_nxt;
    logic [ADDR_W-1:0] cell_addr;
    logic [ADDR_W-1:0] adv_base;
    logic [ROW_W-1:0]  adv_row;
    logic              accept;

    assign vm_ch_ready = (state == IDLE);
    assign accept      = vm_ch_valid && vm_ch_ready;
    assign cell_addr   = row_base + ADDR_W'(col);
    assign adv_row     = (row == LAST_ROW) ? '0 : row + ROW_W'(1);
    assign adv_base    = (row == LAST_ROW) ? '0 : row_base + COLS_A;
    assign vm_cur_col  = col;
    assign vm_cur_row  = row;

    always_comb begin
        state_nxt     = state;
        clr_ptr_nxt   = clr_ptr;
        line_skew_nxt = line_skew;
        col_nxt       = col;
        row_nxt       = row;
        row_base_nxt  = row_base;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = vm_wr_addr;
        wr_data_nxt   = vm_wr_data;

        case (state)
            CLEAR_ALL: begin
                if (clr_ptr < CELLS_A) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = clr_ptr;
                    wr_data_nxt = BLANK;
                    clr_ptr_nxt = clr_ptr + ADDR_W'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end

            // When the row was entered by a printable, cell 0 is cleared here (one
            // cycle behind the character write); after LF it was already written.
            CLEAR_LINE: begin
                if (clr_ptr < COLS_A) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = row_base + clr_ptr;
                    wr_data_nxt = BLANK;
                end
                clr_ptr_nxt = clr_ptr + ADDR_W'(1);
                if (clr_ptr == (line_skew ? COLS_A - ADDR_W'(1) : COLS_A))
                    state_nxt = IDLE;
            end

            IDLE: begin
                if (accept) begin
                    if (vm_ch_in == 8'h0C) begin
                        col_nxt      = '0;
                        row_nxt      = '0;
                        row_base_nxt = '0;
                        wr_en_nxt    = 1'b1;
                        wr_addr_nxt  = '0;
                        wr_data_nxt  = BLANK;
                        clr_ptr_nxt  = ADDR_W'(1);
                        state_nxt    = CLEAR_ALL;
                    end else if (vm_ch_in == 8'h0A) begin
                        col_nxt       = '0;
                        row_nxt       = adv_row;
                        row_base_nxt  = adv_base;
                        wr_en_nxt     = 1'b1;
                        wr_addr_nxt   = adv_base;
                        wr_data_nxt   = BLANK;
                        clr_ptr_nxt   = ADDR_W'(1);
                        line_skew_nxt = 1'b0;
                        state_nxt     = CLEAR_LINE;
                    end else if (vm_ch_in == 8'h0D) begin
                        col_nxt = '0;
                    end else if (vm_ch_in == 8'h08) begin
                        if (col != '0) begin
                            col_nxt     = col - COL_W'(1);
                            wr_en_nxt   = 1'b1;
                            wr_addr_nxt = cell_addr - ADDR_W'(1);
                            wr_data_nxt = BLANK;
                        end
                    end else if (vm_ch_in >= 8'h20 && vm_ch_in != 8'h7F) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = cell_addr;
                        wr_data_nxt = vm_ch_in;
                        if (col < LAST_COL) begin
                            col_nxt = col + COL_W'(1);
                        end else begin
                            col_nxt       = '0;
                            row_nxt       = adv_row;
                            row_base_nxt  = adv_base;
                            clr_ptr_nxt   = '0;
                            line_skew_nxt = 1'b1;
                            state_nxt     = CLEAR_LINE;
                        end
                    end
                end
            end

            default: state_nxt = CLEAR_ALL;
        endcase
    end

    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR_ALL;
            clr_ptr    <= '0;
            line_skew  <= 1'b0;
            col        <= '0;
            row        <= '0;
            row_base   <= '0;
            vm_wr_en   <= 1'b0;
            vm_wr_addr <= '0;
            vm_wr_data <= '0;
        end else begin
            state      <= state_nxt;
            clr_ptr    <= clr_ptr_nxt;
            line_skew  <= line_skew_nxt;
            col        <= col_nxt;
            row        <= row_nxt;
            row_base   <= row_base_nxt;
            vm_wr_en   <= wr_en_nxt;
            vm_wr_addr <= wr_addr_nxt;
            vm_wr_data <= wr_data_nxt;
        end
    end
endmodule

// File: tb/tb_video_term_writer.sv
// tb/tb_video_term_writer.sv - directed self-checking bench for video_term_writer
module tb_video_term_writer;
    localparam int COLS  = 107;
    localparam int ROWS  = 40;
    localparam int CELLS = COLS * ROWS;

    logic        write_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  vm_ch_in = 8'h00;
    logic        vm_ch_valid = 1'b0;
    logic        vm_ch_ready;
    logic [12:0] vm_wr_addr;
    logic [7:0]  vm_wr_data;
    logic        vm_wr_en;
    logic [6:0]  vm_cur_col;
    logic [5:0]  vm_cur_row;

    int checks = 0;
    int failures = 0;

    video_term_writer dut (
        .write_clk   (write_clk),
        .rst_n       (rst_n),
        .vm_ch_in    (vm_ch_in),
        .vm_ch_valid (vm_ch_valid),
        .vm_ch_ready (vm_ch_ready),
        .vm_wr_addr  (vm_wr_addr),
        .vm_wr_data  (vm_wr_data),
        .vm_wr_en    (vm_wr_en),
        .vm_cur_col  (vm_cur_col),
        .vm_cur_row  (vm_cur_row)
    );

    always #5 write_clk = ~write_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] ch;
        bit         wr;
        int         addr;
        int         data;
        int         col;
        int         row;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_cursor(input string name, input int c, input int r);
        chk({name, "_col"}, vm_cur_col, c);
        chk({name, "_row"}, vm_cur_row, r);
    endtask

    // Called at a negedge; the byte is taken at the next posedge.
    task automatic put(input logic [7:0] b);
        vm_ch_in = b;
        vm_ch_valid = 1'b1;
        @(posedge write_clk);
        #1;
        vm_ch_valid = 1'b0;
    endtask

    task automatic expect_full_clear(input string tag);
        int idx = 0;
        int bad = 0;
        bit prev_en = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < CELLS + 20 && !done; i++) begin
            @(negedge write_clk);
            if (vm_ch_ready) begin
                done = 1'b1;
                chk({tag, "_ready_after_last_write"}, int'(prev_en && !vm_wr_en), 1);
            end else begin
                if (vm_wr_en) begin
                    if (vm_wr_addr != idx || vm_wr_data != 8'h20) bad++;
                    idx++;
                end else begin
                    bad++;
                end
                prev_en = vm_wr_en;
            end
        end
        chk({tag, "_finished"}, done, 1);
        chk({tag, "_write_count"}, idx, CELLS);
        chk({tag, "_bad_cycles"}, bad, 0);
        chk_cursor({tag, "_cursor"}, 0, 0);
    endtask

    task automatic expect_clear(input string tag, input int base, input int n, input bit last_ready);
        int bad = 0;
        int rbad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge write_clk);
            if (!vm_wr_en || vm_wr_addr != base + i || vm_wr_data != 8'h20) bad++;
            if (vm_ch_ready != ((i == n - 1) && last_ready)) rbad++;
        end
        chk({tag, "_clear_writes"}, bad, 0);
        chk({tag, "_clear_ready"}, rbad, 0);
    endtask

    initial begin
        int bad;
        bit found;

        vecs[0] = '{8'h41, 1'b1, 0, 8'h41, 1, 0};
        vecs[1] = '{8'h42, 1'b1, 1, 8'h42, 2, 0};
        vecs[2] = '{8'h01, 1'b0, 0, 0,     2, 0};
        vecs[3] = '{8'h7F, 1'b0, 0, 0,     2, 0};
        vecs[4] = '{8'h08, 1'b1, 1, 8'h20, 1, 0};
        vecs[5] = '{8'h80, 1'b1, 1, 8'h80, 2, 0};
        vecs[6] = '{8'h0D, 1'b0, 0, 0,     0, 0};
        vecs[7] = '{8'h08, 1'b0, 0, 0,     0, 0};
        vecs[8] = '{8'h7E, 1'b1, 0, 8'h7E, 1, 0};
        vecs[9] = '{8'h1B, 1'b0, 0, 0,     1, 0};

        repeat (3) @(negedge write_clk);
        chk("rst_wr_en", vm_wr_en, 0);
        chk("rst_wr_addr", vm_wr_addr, 0);
        chk("rst_wr_data", vm_wr_data, 0);
        chk("rst_ready", vm_ch_ready, 0);
        chk_cursor("rst_cursor", 0, 0);

        rst_n = 1'b1;
        expect_full_clear("power_up");

        // Back-to-back table of single-cycle bytes
        for (int i = 0; i < 10; i++) begin
            put(vecs[i].ch);
            @(negedge write_clk);
            chk($sformatf("vec%0d_wr_en", i), vm_wr_en, vecs[i].wr);
            if (vecs[i].wr) begin
                chk($sformatf("vec%0d_addr", i), vm_wr_addr, vecs[i].addr);
                chk($sformatf("vec%0d_data", i), vm_wr_data, vecs[i].data);
            end
            chk($sformatf("vec%0d_ready", i), vm_ch_ready, 1);
            chk_cursor($sformatf("vec%0d", i), vecs[i].col, vecs[i].row);
        end

        // Fill row 0, last column wraps to row 1
        put(8'h0D);
        @(negedge write_clk);
        bad = 0;
        for (int i = 0; i < COLS - 1; i++) begin
            put(8'h78);
            @(negedge write_clk);
            if (!vm_wr_en || vm_wr_addr != i || vm_wr_data != 8'h78 || !vm_ch_ready) bad++;
        end
        chk("row0_fill", bad, 0);
        put(8'h78);
        @(negedge write_clk);
        chk("lastcol_wr_en", vm_wr_en, 1);
        chk("lastcol_addr", vm_wr_addr, 106);
        chk("lastcol_data", vm_wr_data, 8'h78);
        chk("lastcol_ready", vm_ch_ready, 0);
        chk_cursor("lastcol", 0, 1);
        expect_clear("lastcol", 107, COLS, 1'b1);
        chk_cursor("lastcol_after", 0, 1);

        // LF down to the bottom row
        for (int r = 1; r < ROWS - 1; r++) begin
            put(8'h0A);
            expect_clear($sformatf("lf%0d", r), (r + 1) * COLS, COLS, 1'b0);
            @(negedge write_clk);
            chk($sformatf("lf%0d_ready", r), vm_ch_ready, 1);
        end
        chk_cursor("bottom", 0, 39);
        for (int i = 0; i < 5; i++) begin
            put(8'h61);
            @(negedge write_clk);
        end
        chk("bottom_last_addr", vm_wr_addr, 39 * COLS + 4);
        chk_cursor("bottom_col5", 5, 39);

        // LF at the bottom wraps to row 0
        put(8'h0A);
        expect_clear("wrap", 0, COLS, 1'b0);
        chk_cursor("wrap", 0, 0);
        @(negedge write_clk);
        chk("wrap_ready", vm_ch_ready, 1);
        chk("wrap_idle_wr_en", vm_wr_en, 0);
        put(8'h0D);
        @(negedge write_clk);
        chk("cr_wr_en", vm_wr_en, 0);
        put(8'h01);
        @(negedge write_clk);
        chk("ctl01_wr_en", vm_wr_en, 0);
        chk_cursor("ctl01", 0, 0);

        // Backspace at (3,2) and at column 0
        put(8'h0A);
        expect_clear("to_row1", 107, COLS, 1'b0);
        @(negedge write_clk);
        put(8'h0A);
        expect_clear("to_row2", 214, COLS, 1'b0);
        @(negedge write_clk);
        put(8'h61);
        @(negedge write_clk);
        put(8'h62);
        @(negedge write_clk);
        put(8'h63);
        @(negedge write_clk);
        chk_cursor("pre_bs", 3, 2);
        put(8'h08);
        @(negedge write_clk);
        chk("bs_wr_en", vm_wr_en, 1);
        chk("bs_addr", vm_wr_addr, 216);
        chk("bs_data", vm_wr_data, 8'h20);
        chk_cursor("bs", 2, 2);
        put(8'h0D);
        @(negedge write_clk);
        put(8'h08);
        @(negedge write_clk);
        chk("bs_col0_wr_en", vm_wr_en, 0);
        chk_cursor("bs_col0", 0, 2);

        // Form feed mid-screen
        put(8'h7A);
        @(negedge write_clk);
        chk("ff_pre_addr", vm_wr_addr, 214);
        put(8'h0C);
        expect_full_clear("ff");

        // Form feed interrupted by reset at clear write 1000
        put(8'h0C);
        found = 1'b0;
        for (int i = 0; i < 1100 && !found; i++) begin
            @(negedge write_clk);
            if (vm_wr_en && vm_wr_addr == 1000) found = 1'b1;
        end
        chk("abort_point_found", found, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_wr_en", vm_wr_en, 0);
        chk("abort_addr", vm_wr_addr, 0);
        chk("abort_ready", vm_ch_ready, 0);
        repeat (2) @(negedge write_clk);
        rst_n = 1'b1;
        expect_full_clear("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
